// File: rtl/alsu.sv
// Arithmetic-logic-shift unit with registered inputs and registered result.
// Invalid requests blink the leds output every cycle until a valid request arrives.
module alsu #(
    parameter string INPUT_PRIORITY = "A",
    parameter string FULL_ADDER     = "ON"
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  A,
    input  logic [2:0]  B,
    input  logic        cin,
    input  logic        serial_in,
    input  logic        red_op_A,
    input  logic        red_op_B,
    input  logic [2:0]  opcode,
    input  logic        bypass_A,
    input  logic        bypass_B,
    input  logic        direction,
    output logic [15:0] leds,
    output logic [5:0]  out
);

    localparam bit PRIO_A   = (INPUT_PRIORITY == "A");
    localparam bit USE_CARRY = (FULL_ADDER == "ON");

    localparam logic [2:0] OP_AND    = 3'b000;
    localparam logic [2:0] OP_XOR    = 3'b001;
    localparam logic [2:0] OP_ADD    = 3'b010;
    localparam logic [2:0] OP_MULT   = 3'b011;
    localparam logic [2:0] OP_SHIFT  = 3'b100;
    localparam logic [2:0] OP_ROTATE = 3'b101;

    logic [2:0]  a_q, b_q, opcode_q;
    logic        cin_q, serial_in_q, red_op_a_q, red_op_b_q;
    logic        bypass_a_q, bypass_b_q, direction_q;
    logic [5:0]  out_q, out_d;
    logic [15:0] leds_q, leds_d;

    logic        use_a_bypass;
    logic        use_a_reduce;
    logic        invalid;
    logic [5:0]  a_ext, b_ext;

    always_ff @(posedge clk) begin
        if (!rst) begin
            a_q         <= '0;
            b_q         <= '0;
            opcode_q    <= '0;
            cin_q       <= 1'b0;
            serial_in_q <= 1'b0;
            red_op_a_q  <= 1'b0;
            red_op_b_q  <= 1'b0;
            bypass_a_q  <= 1'b0;
            bypass_b_q  <= 1'b0;
            direction_q <= 1'b0;
            out_q       <= '0;
            leds_q      <= '0;
        end else begin
            a_q         <= A;
            b_q         <= B;
            opcode_q    <= opcode;
            cin_q       <= cin;
            serial_in_q <= serial_in;
            red_op_a_q  <= red_op_A;
            red_op_b_q  <= red_op_B;
            bypass_a_q  <= bypass_A;
            bypass_b_q  <= bypass_B;
            direction_q <= direction;
            out_q       <= out_d;
            leds_q      <= leds_d;
        end
    end

    // When both flags of a pair are set, the priority parameter breaks the tie.
    assign use_a_bypass = bypass_a_q && (!bypass_b_q || PRIO_A);
    assign use_a_reduce = red_op_a_q && (!red_op_b_q || PRIO_A);

    assign invalid = (opcode_q[2:1] == 2'b11) ||
                     ((red_op_a_q || red_op_b_q) && (opcode_q[2:1] != 2'b00));

    assign a_ext = {3'b000, a_q};
    assign b_ext = {3'b000, b_q};

    always_comb begin
        out_d  = '0;
        leds_d = '0;
        if (bypass_a_q || bypass_b_q) begin
            out_d = use_a_bypass ? a_ext : b_ext;
        end else if (invalid) begin
            leds_d = ~leds_q;
        end else begin
            case (opcode_q)
                OP_AND: begin
                    if (use_a_reduce)    out_d = {5'b0, &a_q};
                    else if (red_op_b_q) out_d = {5'b0, &b_q};
                    else                 out_d = {3'b0, a_q & b_q};
                end
                OP_XOR: begin
                    if (use_a_reduce)    out_d = {5'b0, ^a_q};
                    else if (red_op_b_q) out_d = {5'b0, ^b_q};
                    else                 out_d = {3'b0, a_q ^ b_q};
                end
                OP_ADD:  out_d = a_ext + b_ext + {5'b0, cin_q & USE_CARRY};
                OP_MULT: out_d = a_ext * b_ext;
                OP_SHIFT: begin
                    if (direction_q) out_d = {out_q[4:0], serial_in_q};
                    else             out_d = {serial_in_q, out_q[5:1]};
                end
                OP_ROTATE: begin
                    if (direction_q) out_d = {out_q[4:0], out_q[5]};
                    else             out_d = {out_q[0], out_q[5:1]};
                end
                default: out_d = '0;
            endcase
        end
    end

    assign out  = out_q;
    assign leds = leds_q;

endmodule

// File: tb/tb_alsu.sv
// Directed bench for alsu: a driver queues expected results, a monitor checks them two edges later.
// Two instances share stimulus so both adder modes are covered in one run.
module tb_alsu;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  A, B, opcode;
    logic        cin, serial_in, red_op_A, red_op_B, bypass_A, bypass_B, direction;
    logic [15:0] leds_on, leds_off;
    logic [5:0]  out_on, out_off;

    typedef struct packed {
        bit          chk;
        logic [5:0]  out_on;
        logic [5:0]  out_off;
        logic [15:0] leds;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   done  = 1'b0;

    always #5 clk = ~clk;

    alsu #(.INPUT_PRIORITY("A"), .FULL_ADDER("ON")) dut_on (
        .clk(clk), .rst(rst), .A(A), .B(B), .cin(cin), .serial_in(serial_in),
        .red_op_A(red_op_A), .red_op_B(red_op_B), .opcode(opcode),
        .bypass_A(bypass_A), .bypass_B(bypass_B), .direction(direction),
        .leds(leds_on), .out(out_on)
    );

    alsu #(.INPUT_PRIORITY("A"), .FULL_ADDER("OFF")) dut_off (
        .clk(clk), .rst(rst), .A(A), .B(B), .cin(cin), .serial_in(serial_in),
        .red_op_A(red_op_A), .red_op_B(red_op_B), .opcode(opcode),
        .bypass_A(bypass_A), .bypass_B(bypass_B), .direction(direction),
        .leds(leds_off), .out(out_off)
    );

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // Vector captured at the previous edge is visible just after this edge.
    initial begin
        exp_t pend;
        bit   have = 1'b0;
        while (!done) begin
            @(posedge clk);
            #1;
            if (have && pend.chk) begin
                check("out_full",  {10'b0, out_on},  {10'b0, pend.out_on});
                check("out_half",  {10'b0, out_off}, {10'b0, pend.out_off});
                check("leds_full", leds_on,  pend.leds);
                check("leds_half", leds_off, pend.leds);
                $display("vec out=%0d/%0d leds=%h/%h exp out=%0d/%0d leds=%h",
                         out_on, out_off, leds_on, leds_off,
                         pend.out_on, pend.out_off, pend.leds);
            end
            have = (exp_q.size() != 0);
            if (have) pend = exp_q.pop_front();
        end
    end

    task automatic apply(input logic r, input logic [2:0] a, input logic [2:0] b,
                         input logic cn, input logic si, input logic ra, input logic rb,
                         input logic [2:0] op, input logic ba, input logic bb, input logic dir,
                         input logic [5:0] e_on, input logic [5:0] e_off,
                         input logic [15:0] e_led, input bit chk);
        exp_t e;
        @(negedge clk);
        rst = r; A = a; B = b; cin = cn; serial_in = si; red_op_A = ra; red_op_B = rb;
        opcode = op; bypass_A = ba; bypass_B = bb; direction = dir;
        e.chk = chk; e.out_on = e_on; e.out_off = e_off; e.leds = e_led;
        exp_q.push_back(e);
    endtask

    task automatic apply_reset();
        apply(1'b0, 3'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom), 1'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom), 6'd0, 6'd0, 16'h0000, 1'b1);
    endtask

    initial begin
        rst = 1'b0; A = '0; B = '0; cin = 0; serial_in = 0; red_op_A = 0; red_op_B = 0;
        opcode = '0; bypass_A = 0; bypass_B = 0; direction = 0;

        apply_reset();
        apply_reset();
        //     rst  A     B     cin si  rA  rB  op      bA  bB  dir exp_on exp_off leds     chk
        apply(1, 3'd3, 3'd5, 1, 0, 0, 0, 3'b010, 0, 0, 0, 6'd9,  6'd8,  16'h0000, 1);
        apply(1, 3'd6, 3'd2, 0, 0, 0, 0, 3'b111, 1, 1, 0, 6'd6,  6'd6,  16'h0000, 1);
        apply(1, 3'd1, 3'd4, 0, 0, 0, 0, 3'b000, 0, 1, 0, 6'd4,  6'd4,  16'h0000, 1);
        apply(1, 3'd2, 3'd3, 0, 0, 0, 0, 3'b110, 0, 0, 0, 6'd0,  6'd0,  16'hFFFF, 1);
        apply(1, 3'd2, 3'd3, 0, 0, 0, 0, 3'b110, 0, 0, 0, 6'd0,  6'd0,  16'h0000, 1);
        apply(1, 3'd2, 3'd3, 0, 0, 0, 0, 3'b110, 0, 0, 0, 6'd0,  6'd0,  16'hFFFF, 1);
        apply(1, 3'd2, 3'd3, 0, 0, 0, 0, 3'b110, 0, 0, 0, 6'd0,  6'd0,  16'h0000, 1);
        apply(1, 3'd7, 3'd7, 0, 0, 0, 1, 3'b011, 0, 0, 0, 6'd0,  6'd0,  16'hFFFF, 1);
        apply(1, 3'd7, 3'd7, 0, 0, 0, 1, 3'b011, 0, 0, 0, 6'd0,  6'd0,  16'h0000, 1);
        apply_reset();
        apply(1, 3'd1, 3'd1, 0, 0, 0, 0, 3'b111, 0, 0, 0, 6'd0,  6'd0,  16'hFFFF, 1);
        apply(1, 3'd7, 3'd3, 0, 0, 1, 0, 3'b000, 0, 0, 0, 6'd1,  6'd1,  16'h0000, 1);
        apply(1, 3'd7, 3'd3, 0, 0, 1, 1, 3'b000, 0, 0, 0, 6'd1,  6'd1,  16'h0000, 1);
        apply(1, 3'd0, 3'd7, 0, 0, 0, 1, 3'b000, 0, 0, 0, 6'd1,  6'd1,  16'h0000, 1);
        apply(1, 3'd7, 3'd3, 0, 0, 0, 1, 3'b001, 0, 0, 0, 6'd0,  6'd0,  16'h0000, 1);
        apply(1, 3'd5, 3'd3, 0, 0, 0, 0, 3'b001, 0, 0, 0, 6'd6,  6'd6,  16'h0000, 1);
        apply(1, 3'd7, 3'd7, 0, 0, 0, 0, 3'b011, 0, 0, 0, 6'd49, 6'd49, 16'h0000, 1);
        apply(1, 3'd7, 3'd7, 1, 0, 0, 0, 3'b010, 0, 0, 0, 6'd15, 6'd14, 16'h0000, 1);
        apply(1, 3'd5, 3'd0, 0, 0, 0, 0, 3'b000, 1, 0, 0, 6'd5,  6'd5,  16'h0000, 1);
        apply(1, 3'd0, 3'd0, 0, 1, 0, 0, 3'b100, 0, 0, 1, 6'd11, 6'd11, 16'h0000, 1);
        apply(1, 3'd0, 3'd0, 0, 0, 0, 0, 3'b101, 0, 0, 0, 6'd37, 6'd37, 16'h0000, 1);
        apply(1, 3'd0, 3'd0, 0, 0, 0, 0, 3'b101, 0, 0, 1, 6'd11, 6'd11, 16'h0000, 1);
        apply(1, 3'd0, 3'd0, 0, 0, 0, 0, 3'b100, 0, 0, 0, 6'd5,  6'd5,  16'h0000, 1);
        apply(1, 3'd0, 3'd0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 6'd0,  6'd0,  16'h0000, 0);
        apply(1, 3'd0, 3'd0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 6'd0,  6'd0,  16'h0000, 0);
        repeat (4) @(posedge clk);
        done = 1'b1;
        #2;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
